// File: rtl/aoc_grid_pkg.sv
// rtl/aoc_grid_pkg.sv - shared grid types: move directions, coordinate and record layouts
package aoc_grid_pkg;

    // One-hot move encodings as produced by the direction decoder.
    typedef enum logic [3:0] {
        N_DIR = 4'b1000,
        E_DIR = 4'b0100,
        S_DIR = 4'b0010,
        W_DIR = 4'b0001
    } dir_t;

    localparam int DEFAULT_POSITION_WIDTH = 16;
    localparam int DEFAULT_AGENT_WIDTH    = 1;

    typedef logic [DEFAULT_POSITION_WIDTH-1:0] position_t;

    // Record layout at default widths; the tracker mirrors it with its own parameter widths.
    typedef struct packed {
        logic [DEFAULT_AGENT_WIDTH-1:0] agent;
        position_t                      x;
        position_t                      y;
    } pos_record_t;

    // Agent index width, never narrower than one bit so a single agent still has a port.
    function automatic int agent_width(input int num_agents);
        return (num_agents > 1) ? $clog2(num_agents) : 1;
    endfunction

    // A move is usable only when exactly one direction bit is set.
    function automatic logic dir_is_legal(input logic [3:0] dir);
        return $onehot(dir);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with full/empty flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer registers; reset discards any stored records.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/multi_agent_position_tracker.sv
// rtl/multi_agent_position_tracker.sv - round-robin grid position tracker with buffered record output
module multi_agent_position_tracker
    import aoc_grid_pkg::*;
#(
    parameter int  POSITION_WIDTH = 16,
    parameter int  NUM_AGENTS     = 2,
    parameter int  FIFO_DEPTH     = 4,
    localparam int AGENT_WIDTH    = agent_width(NUM_AGENTS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      shift_valid,
    output logic                      shift_ready,
    input  logic [3:0]                shift_direction,
    output logic                      pos_valid,
    input  logic                      pos_ready,
    output logic [AGENT_WIDTH-1:0]    pos_agent,
    output logic [POSITION_WIDTH-1:0] pos_x,
    output logic [POSITION_WIDTH-1:0] pos_y,
    output logic                      pos_error,
    output logic [31:0]               moves_accepted
);
    typedef logic [POSITION_WIDTH-1:0] coord_t;

    typedef struct packed {
        logic [AGENT_WIDTH-1:0] agent;
        coord_t                 x;
        coord_t                 y;
    } rec_t;

    coord_t                 agent_x [NUM_AGENTS];
    coord_t                 agent_y [NUM_AGENTS];
    logic [AGENT_WIDTH-1:0] ptr;
    logic                   origin_pending;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   accept;
    logic                   legal;
    logic                   fifo_wr;
    coord_t                 cur_x;
    coord_t                 cur_y;
    coord_t                 step_x;
    coord_t                 step_y;
    coord_t                 next_x;
    coord_t                 next_y;
    rec_t                   wr_rec;
    rec_t                   rd_rec;

    // Ready depends only on registered state, never on the downstream pos_ready.
    assign shift_ready = !origin_pending && !fifo_full;
    assign accept      = shift_valid && shift_ready;
    assign legal       = dir_is_legal(shift_direction);
    assign cur_x       = agent_x[ptr];
    assign cur_y       = agent_y[ptr];
    assign next_x      = cur_x + step_x;
    assign next_y      = cur_y + step_y;
    assign fifo_wr     = origin_pending || (accept && legal);

    // Per-axis step: all-ones is -1, so one adder per axis covers both directions with wrap.
    always_comb begin
        step_x = '0;
        step_y = '0;
        case (shift_direction)
            N_DIR:   step_y = coord_t'(1);
            S_DIR:   step_y = '1;
            E_DIR:   step_x = coord_t'(1);
            W_DIR:   step_x = '1;
            default: ;
        endcase
    end

    // The origin record takes the first write slot; afterwards records carry the moved agent.
    always_comb begin
        wr_rec = '0;
        if (!origin_pending) begin
            wr_rec.agent = ptr;
            wr_rec.x     = next_x;
            wr_rec.y     = next_y;
        end
    end

    // Control state: origin flag, round-robin pointer, sticky error and saturating move count.
    always_ff @(posedge clk) begin
        if (reset) begin
            origin_pending <= 1'b1;
            ptr            <= '0;
            pos_error      <= 1'b0;
            moves_accepted <= '0;
        end else begin
            origin_pending <= 1'b0;
            if (accept) begin
                ptr <= (ptr == AGENT_WIDTH'(NUM_AGENTS - 1)) ? '0 : ptr + AGENT_WIDTH'(1);
                if (moves_accepted != '1) moves_accepted <= moves_accepted + 32'd1;
                if (!legal) pos_error <= 1'b1;
            end
        end
    end

    // Agent positions; an illegal move consumes its slot but leaves the agent in place.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_AGENTS; i++) begin
                agent_x[i] <= '0;
                agent_y[i] <= '0;
            end
        end else if (accept && legal) begin
            agent_x[ptr] <= next_x;
            agent_y[ptr] <= next_y;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(rec_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (fifo_wr),
        .wr_data (wr_rec),
        .full    (fifo_full),
        .rd_en   (pos_valid && pos_ready),
        .rd_data (rd_rec),
        .empty   (fifo_empty)
    );

    assign pos_valid = !fifo_empty;
    assign pos_agent = rd_rec.agent;
    assign pos_x     = rd_rec.x;
    assign pos_y     = rd_rec.y;

endmodule

// File: tb/tb_multi_agent_position_tracker.sv
// tb/tb_multi_agent_position_tracker.sv - directed-vector bench for multi_agent_position_tracker
module tb_multi_agent_position_tracker;

    logic        clk = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;

    // Two-agent, 16-bit instance
    logic        reset, shift_valid, pos_ready;
    logic [3:0]  shift_direction;
    logic        shift_ready, pos_valid, pos_error;
    logic [0:0]  pos_agent;
    logic [15:0] pos_x, pos_y;
    logic [31:0] moves_accepted;

    // Single-agent, 4-bit instance
    logic        b_reset, b_shift_valid, b_pos_ready;
    logic [3:0]  b_shift_direction;
    logic        b_shift_ready, b_pos_valid, b_pos_error;
    logic [0:0]  b_pos_agent;
    logic [3:0]  b_pos_x, b_pos_y;
    logic [31:0] b_moves_accepted;

    always #5 clk = ~clk;

    multi_agent_position_tracker #(
        .POSITION_WIDTH (16),
        .NUM_AGENTS     (2),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .shift_valid     (shift_valid),
        .shift_ready     (shift_ready),
        .shift_direction (shift_direction),
        .pos_valid       (pos_valid),
        .pos_ready       (pos_ready),
        .pos_agent       (pos_agent),
        .pos_x           (pos_x),
        .pos_y           (pos_y),
        .pos_error       (pos_error),
        .moves_accepted  (moves_accepted)
    );

    multi_agent_position_tracker #(
        .POSITION_WIDTH (4),
        .NUM_AGENTS     (1),
        .FIFO_DEPTH     (4)
    ) dut_b (
        .clk             (clk),
        .reset           (b_reset),
        .shift_valid     (b_shift_valid),
        .shift_ready     (b_shift_ready),
        .shift_direction (b_shift_direction),
        .pos_valid       (b_pos_valid),
        .pos_ready       (b_pos_ready),
        .pos_agent       (b_pos_agent),
        .pos_x           (b_pos_x),
        .pos_y           (b_pos_y),
        .pos_error       (b_pos_error),
        .moves_accepted  (b_moves_accepted)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rec(input string tag, input logic a, input logic [15:0] x, input logic [15:0] y);
        chk({tag, ".valid"}, 64'(pos_valid), 64'd1);
        chk({tag, ".agent"}, 64'(pos_agent), 64'(a));
        chk({tag, ".x"},     64'(pos_x),     64'(x));
        chk({tag, ".y"},     64'(pos_y),     64'(y));
    endtask

    // One isolated move with an always-ready consumer: record appears, then is consumed.
    task automatic one_move(input string tag, input logic [3:0] dir, input logic a,
                            input logic [15:0] x, input logic [15:0] y);
        chk({tag, ".ready"}, 64'(shift_ready), 64'd1);
        shift_valid = 1'b1;
        shift_direction = dir;
        tick();
        shift_valid = 1'b0;
        expect_rec(tag, a, x, y);
        tick();
        chk({tag, ".drained"}, 64'(pos_valid), 64'd0);
    endtask

    initial begin
        reset = 1'b1; shift_valid = 1'b0; shift_direction = 4'b0000; pos_ready = 1'b1;
        b_reset = 1'b1; b_shift_valid = 1'b0; b_shift_direction = 4'b0000; b_pos_ready = 1'b1;
        tick();
        tick();
        chk("rst.pos_valid",   64'(pos_valid),      64'd0);
        chk("rst.shift_ready", 64'(shift_ready),    64'd0);
        chk("rst.pos_error",   64'(pos_error),      64'd0);
        chk("rst.moves",       64'(moves_accepted), 64'd0);

        // Origin emitted once, shift_ready held low until it is written
        reset = 1'b0;
        chk("orig.ready_pre", 64'(shift_ready), 64'd0);
        tick();
        expect_rec("orig", 1'b0, 16'h0000, 16'h0000);
        chk("orig.ready_post", 64'(shift_ready), 64'd1);
        tick();
        chk("orig.once1", 64'(pos_valid), 64'd0);
        tick();
        tick();
        chk("orig.once2", 64'(pos_valid), 64'd0);

        // Round-robin moves N,S,E,W
        one_move("m_n", 4'b1000, 1'b0, 16'h0000, 16'h0001);
        one_move("m_s", 4'b0010, 1'b1, 16'h0000, 16'hFFFF);
        one_move("m_e", 4'b0100, 1'b0, 16'h0001, 16'h0001);
        one_move("m_w", 4'b0001, 1'b1, 16'hFFFF, 16'hFFFF);
        chk("rr.err",   64'(pos_error),      64'd0);
        chk("rr.moves", 64'(moves_accepted), 64'd4);

        // Multi-hot move on agent0 consumes the slot without a record
        shift_valid = 1'b1; shift_direction = 4'b0110;
        tick();
        shift_valid = 1'b0;
        chk("bad.no_rec", 64'(pos_valid),      64'd0);
        chk("bad.err",    64'(pos_error),      64'd1);
        chk("bad.moves",  64'(moves_accepted), 64'd5);
        one_move("bad.n_a1", 4'b1000, 1'b1, 16'hFFFF, 16'h0000);
        one_move("bad.n_a0", 4'b1000, 1'b0, 16'h0001, 16'h0002);
        chk("bad.sticky", 64'(pos_error),      64'd1);
        chk("bad.moves2", 64'(moves_accepted), 64'd7);

        // Backpressure: fresh start, consumer stalled, continuous E moves
        reset = 1'b1;
        tick();
        reset = 1'b0; pos_ready = 1'b0; shift_valid = 1'b1; shift_direction = 4'b0100;
        for (int i = 0; i < 6; i++) tick();
        chk("bp.ready",  64'(shift_ready),    64'd0);
        chk("bp.moves",  64'(moves_accepted), 64'd3);
        chk("bp.err",    64'(pos_error),      64'd0);
        expect_rec("bp.head", 1'b0, 16'h0000, 16'h0000);
        // Read while full: write still blocked this edge, ready returns next cycle
        pos_ready = 1'b1;
        tick();
        shift_valid = 1'b0;
        chk("bp.ready_back", 64'(shift_ready),    64'd1);
        chk("bp.moves_hold", 64'(moves_accepted), 64'd3);
        expect_rec("bp.r1", 1'b0, 16'h0001, 16'h0000);
        tick();
        expect_rec("bp.r2", 1'b1, 16'h0001, 16'h0000);
        tick();
        expect_rec("bp.r3", 1'b0, 16'h0002, 16'h0000);
        tick();
        chk("bp.empty", 64'(pos_valid), 64'd0);

        // Fill again (pointer at agent1), then reset mid-stream
        pos_ready = 1'b0; shift_valid = 1'b1; shift_direction = 4'b0100;
        for (int i = 0; i < 5; i++) tick();
        chk("mid.full",  64'(shift_ready),    64'd0);
        chk("mid.moves", 64'(moves_accepted), 64'd7);
        reset = 1'b1;
        tick();
        reset = 1'b0; shift_valid = 1'b0; pos_ready = 1'b1;
        chk("mid.valid0", 64'(pos_valid),      64'd0);
        chk("mid.moves0", 64'(moves_accepted), 64'd0);
        tick();
        expect_rec("mid.orig", 1'b0, 16'h0000, 16'h0000);
        tick();
        chk("mid.orig_once", 64'(pos_valid), 64'd0);
        one_move("mid.a0", 4'b1000, 1'b0, 16'h0000, 16'h0001);
        one_move("mid.a1", 4'b0100, 1'b1, 16'h0001, 16'h0000);

        // Single agent, 4-bit coordinates: wrap behaviour
        b_reset = 1'b0;
        tick();
        chk("b.orig_v", 64'(b_pos_valid), 64'd1);
        chk("b.orig_x", 64'(b_pos_x),     64'd0);
        tick();
        b_shift_valid = 1'b1; b_shift_direction = 4'b0001;
        tick();
        b_shift_direction = 4'b0100;
        chk("b.w_v",     64'(b_pos_valid), 64'd1);
        chk("b.w_agent", 64'(b_pos_agent), 64'd0);
        chk("b.w_x",     64'(b_pos_x),     64'hF);
        chk("b.w_y",     64'(b_pos_y),     64'h0);
        tick();
        chk("b.e1_x", 64'(b_pos_x), 64'h0);
        for (int i = 0; i < 15; i++) tick();
        b_shift_valid = 1'b0;
        chk("b.e16_v",     64'(b_pos_valid),      64'd1);
        chk("b.e16_agent", 64'(b_pos_agent),      64'd0);
        chk("b.e16_x",     64'(b_pos_x),          64'hF);
        chk("b.moves",     64'(b_moves_accepted), 64'd17);
        chk("b.err",       64'(b_pos_error),      64'd0);
        tick();
        chk("b.drained", 64'(b_pos_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
